// File: rtl/pifo_dequeue_sched.sv
// PIFO dequeue scheduler: pops the head flow into a one-entry egress register,
// reinserts the flow with an aged priority while it still has backlog, keeps
// per-flow packet counts and offers run/pause/flush control.
//
// Egress handshake: a grant transfers on any cycle where o__deq_valid and
// i__deq_ready are both high. Once o__deq_valid is raised, o__deq_flow and
// o__deq_priority stay stable and o__deq_valid stays high until that transfer
// (only a flush or reset withdraws a pending grant). i__deq_ready may be driven
// freely and is never required before o__deq_valid.
module pifo_dequeue_sched #(
  parameter int NUM_FLOWS    = 16,
  parameter int MAX_PRIORITY = 256,
  parameter int CNT_WIDTH    = 8,
  parameter int AGE_STEP     = 16,
  localparam int PRIO_WIDTH  = $clog2(MAX_PRIORITY),
  localparam int FLOW_WIDTH  = $clog2(NUM_FLOWS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i__pop_valid,
  input  logic [PRIO_WIDTH-1:0] i__pop_priority,
  input  logic [FLOW_WIDTH-1:0] i__pop_data,
  output logic                  o__pop,
  output logic [PRIO_WIDTH-1:0] o__reinsert_priority,
  output logic                  o__clear_all,
  input  logic                  i__arrive_valid,
  input  logic [FLOW_WIDTH-1:0] i__arrive_flow,
  output logic                  o__arrive_drop,
  output logic                  o__new_flow_valid,
  output logic [FLOW_WIDTH-1:0] o__new_flow_id,
  output logic                  o__deq_valid,
  output logic [FLOW_WIDTH-1:0] o__deq_flow,
  output logic [PRIO_WIDTH-1:0] o__deq_priority,
  input  logic                  i__deq_ready,
  input  logic                  i__enable,
  input  logic                  i__flush,
  output logic [1:0]            o__dbg_state
);

  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;
  localparam logic [PRIO_WIDTH-1:0] AGE     = PRIO_WIDTH'(AGE_STEP);

  state_e state_q, state_d;

  logic [CNT_WIDTH-1:0] cnt_q [NUM_FLOWS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_FLOWS];

  logic                  deq_valid_q, deq_valid_d;
  logic [FLOW_WIDTH-1:0] deq_flow_q, deq_flow_d;
  logic [PRIO_WIDTH-1:0] deq_prio_q, deq_prio_d;

  logic                  drop_q, drop_d;
  logic                  new_flow_q, new_flow_d;
  logic [FLOW_WIDTH-1:0] new_flow_id_q, new_flow_id_d;

  logic                  pop_w;
  logic                  arrive_ok;
  logic [CNT_WIDTH-1:0]  arr_cnt;
  logic                  arr_sat;
  logic                  arr_inc;
  logic                  arr_same;
  logic [CNT_WIDTH-1:0]  eff_cnt;
  logic [PRIO_WIDTH-1:0] aged_prio;

  // A pop happens only while running and when the egress slot is free or freeing.
  assign pop_w = (state_q == ST_RUN) && i__pop_valid && (!deq_valid_q || i__deq_ready);

  // Aged priority never reaches 0, since 0 means "no reinsert" to the PIFO.
  assign aged_prio = (i__pop_priority > AGE) ? (i__pop_priority - AGE) : PRIO_WIDTH'(1);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_PAUSE;
    else          state_q <= state_d;
  end

  // Next-state logic; flush wins over enable, and FLUSH always lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PAUSE: begin
        if (i__flush)       state_d = ST_FLUSH;
        else if (i__enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (i__flush)        state_d = ST_FLUSH;
        else if (!i__enable) state_d = ST_PAUSE;
      end
      ST_FLUSH: state_d = ST_PAUSE;
      default:  state_d = ST_PAUSE;
    endcase
  end

  // Backlog accounting: saturating arrivals, floor-0 pops, arrival pulses.
  always_comb begin
    cnt_d         = cnt_q;
    arrive_ok     = i__arrive_valid && (state_q != ST_FLUSH);
    arr_cnt       = cnt_q[i__arrive_flow];
    arr_sat       = (arr_cnt == CNT_MAX);
    arr_inc       = arrive_ok && !arr_sat;
    arr_same      = arr_inc && (i__arrive_flow == i__pop_data);
    eff_cnt       = cnt_q[i__pop_data] + CNT_WIDTH'(arr_same);
    new_flow_d    = arr_inc && (arr_cnt == '0) && !(pop_w && (i__arrive_flow == i__pop_data));
    new_flow_id_d = new_flow_d ? i__arrive_flow : new_flow_id_q;
    drop_d        = arrive_ok && arr_sat;
    if (arr_inc) cnt_d[i__arrive_flow] = arr_cnt + CNT_WIDTH'(1);
    // The pop update already folds in a same-flow arrival through eff_cnt.
    if (pop_w) cnt_d[i__pop_data] = (eff_cnt == '0) ? '0 : (eff_cnt - CNT_WIDTH'(1));
    if (state_q == ST_FLUSH) begin
      for (int i = 0; i < NUM_FLOWS; i++) cnt_d[i] = '0;
    end
  end

  // Egress register: load on pop, hold while stalled, empty on accept or flush.
  always_comb begin
    deq_valid_d = deq_valid_q;
    deq_flow_d  = deq_flow_q;
    deq_prio_d  = deq_prio_q;
    if (pop_w) begin
      deq_valid_d = 1'b1;
      deq_flow_d  = i__pop_data;
      deq_prio_d  = i__pop_priority;
    end else if (deq_valid_q && i__deq_ready) begin
      deq_valid_d = 1'b0;
    end
    if (state_d == ST_FLUSH) deq_valid_d = 1'b0;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_FLOWS; i++) cnt_q[i] <= '0;
      deq_valid_q   <= 1'b0;
      deq_flow_q    <= '0;
      deq_prio_q    <= '0;
      drop_q        <= 1'b0;
      new_flow_q    <= 1'b0;
      new_flow_id_q <= '0;
    end else begin
      cnt_q         <= cnt_d;
      deq_valid_q   <= deq_valid_d;
      deq_flow_q    <= deq_flow_d;
      deq_prio_q    <= deq_prio_d;
      drop_q        <= drop_d;
      new_flow_q    <= new_flow_d;
      new_flow_id_q <= new_flow_id_d;
    end
  end

  assign o__pop               = pop_w;
  assign o__reinsert_priority = (pop_w && (eff_cnt > CNT_WIDTH'(1))) ? aged_prio : '0;
  assign o__clear_all         = (state_q == ST_FLUSH);
  assign o__arrive_drop       = drop_q;
  assign o__new_flow_valid    = new_flow_q;
  assign o__new_flow_id       = new_flow_id_q;
  assign o__deq_valid         = deq_valid_q;
  assign o__deq_flow          = deq_flow_q;
  assign o__deq_priority      = deq_prio_q;
  assign o__dbg_state         = state_q;

endmodule
